// File: rtl/accum_addsub_4bit_pkg.sv
// ----------------------------------------------------------------------------
// accum_addsub_4bit_pkg
// Shared definitions for the accumulate add/subtract sequencer:
//   - state_t : sequencer FSM states (IDLE/LOAD/RUN/DONE)
//   - OP_ADD / OP_SUB : values of the m (mode) input
//   - DATA_W : operand / accumulator width
// ----------------------------------------------------------------------------
package accum_addsub_4bit_pkg;

   localparam int DATA_W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage : accum_addsub_4bit_pkg

// File: rtl/fulladder_4_bit.sv
// ----------------------------------------------------------------------------
// fulladder_4_bit
// Combinational 4-bit ripple adder/subtractor.
//   a, b  in  4  operands
//   m     in  1  0 = add (a + b), 1 = subtract (a + ~b + 1)
//   s     out 4  result, modulo 16
//   cout  out 1  carry out; for subtract, 1 means no borrow
// ----------------------------------------------------------------------------
module fulladder_4_bit
   import accum_addsub_4bit_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              m,
   output logic [DATA_W-1:0] s,
   output logic              cout
);

   logic [DATA_W-1:0] bx;
   logic [DATA_W:0]   c;

   // Subtraction is two's complement: invert b and inject m as carry-in.
   assign bx   = b ^ {DATA_W{m}};
   assign c[0] = m;

   for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      assign s[i]   = a[i] ^ bx[i] ^ c[i];
      assign c[i+1] = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
   end

   assign cout = c[DATA_W];

endmodule : fulladder_4_bit

// File: rtl/accum_addsub_4bit.sv
// ----------------------------------------------------------------------------
// accum_addsub_4bit
// Sequencing stage around fulladder_4_bit. After start, accepts NUM_OPS
// operands over a valid/ready handshake: the first loads the accumulator,
// each following one is added to / subtracted from it. Sum and carry are
// registered back into the accumulator and signed overflow is kept sticky.
//   clk       in  1  clock, rising edge
//   rst       in  1  synchronous active-high reset
//   start     in  1  begin a sequence (honoured only in IDLE)
//   in_valid  in  1  operand present
//   in_ready  out 1  operand accepted this cycle when in_valid is high
//   operand   in  4  operand value
//   m         in  1  0 = add, 1 = subtract (acc - operand)
//   acc       out 4  accumulator
//   carry     out 1  adder cout of last accepted operation
//   ovf       out 1  sticky signed overflow for current sequence
//   count     out 4  operands accepted in current sequence
//   done      out 1  one-cycle completion pulse
// ----------------------------------------------------------------------------
module accum_addsub_4bit
   import accum_addsub_4bit_pkg::*;
#(
   parameter int NUM_OPS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] operand,
   input  logic              m,
   output logic [DATA_W-1:0] acc,
   output logic              carry,
   output logic              ovf,
   output logic [3:0]        count,
   output logic              done
);

   if (NUM_OPS < 2 || NUM_OPS > 15) begin : g_bad_num_ops
      $error("accum_addsub_4bit: NUM_OPS must be in 2..15");
   end

   localparam logic [3:0] LAST_CNT = 4'(NUM_OPS);

   // Signed overflow of acc (+/-) operand, judged on sign bits only.
   function automatic logic ovf_detect(input logic a_msb, input logic b_msb,
                                       input logic s_msb, input logic sub);
      logic same_sign;
      same_sign = (a_msb == b_msb);
      return (sub ? !same_sign : same_sign) && (s_msb != a_msb);
   endfunction

   state_t            state, state_nxt;
   logic              accept;
   logic [DATA_W-1:0] sum;
   logic              cout;
   logic [3:0]        count_nxt;
   logic              ovf_now;

   fulladder_4_bit u_adder (
      .a    (acc),
      .b    (operand),
      .m    (m),
      .s    (sum),
      .cout (cout)
   );

   assign accept    = in_valid & in_ready;
   assign count_nxt = count + 4'd1;
   assign ovf_now   = ovf_detect(acc[DATA_W-1], operand[DATA_W-1],
                                 sum[DATA_W-1], m == OP_SUB);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)  state_nxt = ST_LOAD;
         ST_LOAD: if (accept) state_nxt = ST_RUN;
         ST_RUN:  if (accept && count_nxt == LAST_CNT) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: pure state decode, no path from in_valid or start.
   always_comb begin
      in_ready = 1'b0;
      done     = 1'b0;
      case (state)
         ST_LOAD, ST_RUN: in_ready = 1'b1;
         ST_DONE:         done     = 1'b1;
         default:         ;
      endcase
   end

   // Accumulator / status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         carry <= 1'b0;
         ovf   <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               acc   <= '0;
               carry <= 1'b0;
               ovf   <= 1'b0;
               count <= '0;
            end
            ST_LOAD: if (accept) begin
               acc   <= operand;
               carry <= 1'b0;
               count <= 4'd1;
            end
            ST_RUN: if (accept) begin
               acc   <= sum;
               carry <= cout;
               ovf   <= ovf | ovf_now;
               count <= count_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule : accum_addsub_4bit

// File: tb/tb_accum_addsub_4bit.sv
// ----------------------------------------------------------------------------
// tb_accum_addsub_4bit
// Directed-vector bench for accum_addsub_4bit (NUM_OPS = 4). Inputs change
// 1 ns after each rising edge; outputs are checked at that same point.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_accum_addsub_4bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] operand;
   logic       m;
   logic [3:0] acc;
   logic       carry;
   logic       ovf;
   logic [3:0] count;
   logic       done;

   int n_vec = 0;
   int n_err = 0;

   accum_addsub_4bit #(.NUM_OPS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .operand  (operand),
      .m        (m),
      .acc      (acc),
      .carry    (carry),
      .ovf      (ovf),
      .count    (count),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] e_acc, input logic e_carry,
                          input logic e_ovf, input logic [3:0] e_count,
                          input logic e_done, input logic e_rdy);
      check({tag, ".acc"},   acc,      e_acc);
      check({tag, ".carry"}, carry,    e_carry);
      check({tag, ".ovf"},   ovf,      e_ovf);
      check({tag, ".count"}, count,    e_count);
      check({tag, ".done"},  done,     e_done);
      check({tag, ".rdy"},   in_ready, e_rdy);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Present one operand for one edge; in_valid drops afterwards unless the
   // caller presents another immediately.
   task automatic send(input logic [3:0] op, input logic mm);
      in_valid = 1'b1;
      operand  = op;
      m        = mm;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b1;
      operand  = 4'h9;
      m        = 1'b0;

      // Reset, with in_valid high throughout
      step();
      step();
      chk_all("rst", 4'h0, 0, 0, 4'd0, 0, 0);
      rst = 1'b0;
      step();
      step();
      chk_all("idle_valid", 4'h0, 0, 0, 4'd0, 0, 0);
      in_valid = 1'b0;

      // Add chain 1,2,3,1
      do_start();
      chk_all("add.load_st", 4'h0, 0, 0, 4'd0, 0, 1);
      send(4'd1, 1'b0); chk_all("add.1", 4'h1, 0, 0, 4'd1, 0, 1);
      send(4'd2, 1'b0); chk_all("add.2", 4'h3, 0, 0, 4'd2, 0, 1);
      send(4'd3, 1'b0); chk_all("add.3", 4'h6, 0, 0, 4'd3, 0, 1);
      send(4'd1, 1'b0); chk_all("add.4", 4'h7, 0, 0, 4'd4, 1, 0);
      step();           chk_all("add.idle", 4'h7, 0, 0, 4'd4, 0, 0);

      // Subtract chain: load 5 (m ignored on load), then -1,-1,-1
      do_start();
      chk_all("sub.clr", 4'h0, 0, 0, 4'd0, 0, 1);
      send(4'd5, 1'b1); chk_all("sub.load", 4'h5, 0, 0, 4'd1, 0, 1);
      send(4'd1, 1'b1); chk_all("sub.1", 4'h4, 1, 0, 4'd2, 0, 1);
      send(4'd1, 1'b1); chk_all("sub.2", 4'h3, 1, 0, 4'd3, 0, 1);
      send(4'd1, 1'b1); chk_all("sub.3", 4'h2, 1, 0, 4'd4, 1, 0);
      // start during DONE must be ignored
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("sub.done_start", 4'h2, 1, 0, 4'd4, 0, 0);
      step();
      chk_all("sub.still_idle", 4'h2, 1, 0, 4'd4, 0, 0);

      // Wrap and overflow: load F, +1, +7, +1
      do_start();
      send(4'hF, 1'b0); chk_all("wrap.load", 4'hF, 0, 0, 4'd1, 0, 1);
      send(4'h1, 1'b0); chk_all("wrap.1", 4'h0, 1, 0, 4'd2, 0, 1);
      send(4'h7, 1'b0); chk_all("wrap.2", 4'h7, 0, 0, 4'd3, 0, 1);
      send(4'h1, 1'b0); chk_all("wrap.3", 4'h8, 0, 1, 4'd4, 1, 0);
      step();           chk_all("wrap.idle", 4'h8, 0, 1, 4'd4, 0, 0);

      // Handshake gaps with start pulsed mid-RUN; same data as add chain
      do_start();
      step();           chk_all("gap.load_wait", 4'h0, 0, 0, 4'd0, 0, 1);
      send(4'd1, 1'b0); chk_all("gap.1", 4'h1, 0, 0, 4'd1, 0, 1);
      step();           chk_all("gap.1a", 4'h1, 0, 0, 4'd1, 0, 1);
      step();           chk_all("gap.1b", 4'h1, 0, 0, 4'd1, 0, 1);
      send(4'd2, 1'b0); chk_all("gap.2", 4'h3, 0, 0, 4'd2, 0, 1);
      start = 1'b1;
      step();
      start = 1'b0;     chk_all("gap.start", 4'h3, 0, 0, 4'd2, 0, 1);
      step();           chk_all("gap.2b", 4'h3, 0, 0, 4'd2, 0, 1);
      send(4'd3, 1'b0); chk_all("gap.3", 4'h6, 0, 0, 4'd3, 0, 1);
      step();           chk_all("gap.3a", 4'h6, 0, 0, 4'd3, 0, 1);
      step();           chk_all("gap.3b", 4'h6, 0, 0, 4'd3, 0, 1);
      send(4'd1, 1'b0); chk_all("gap.4", 4'h7, 0, 0, 4'd4, 1, 0);
      step();           chk_all("gap.idle", 4'h7, 0, 0, 4'd4, 0, 0);

      // Reset mid-RUN, then a fresh subtract sequence 2,-3,-1,-8
      do_start();
      send(4'd3, 1'b0); chk_all("mid.1", 4'h3, 0, 0, 4'd1, 0, 1);
      send(4'd4, 1'b0); chk_all("mid.2", 4'h7, 0, 0, 4'd2, 0, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_all("mid.rst", 4'h0, 0, 0, 4'd0, 0, 0);
      do_start();
      send(4'd2, 1'b1); chk_all("post.load", 4'h2, 0, 0, 4'd1, 0, 1);
      send(4'd3, 1'b1); chk_all("post.1", 4'hF, 0, 0, 4'd2, 0, 1);
      send(4'd1, 1'b1); chk_all("post.2", 4'hE, 1, 0, 4'd3, 0, 1);
      send(4'd8, 1'b1); chk_all("post.3", 4'h6, 1, 0, 4'd4, 1, 0);
      step();           chk_all("post.idle", 4'h6, 1, 0, 4'd4, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_accum_addsub_4bit
